// File: rtl/result_collector_128x1_if.sv
// Handshake bundle for the 128-element result collector: 8-lane beat input, one-element drain output.
interface result_collector_128x1_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [8*DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [6:0]        out_idx;
    logic [3:0]        beat_cnt;
    logic              frame_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, beat_cnt, frame_done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, beat_cnt, frame_done
    );
endinterface

// File: rtl/result_collector_128x1.sv
// Collects 16 beats of 8 lanes into a 128-entry buffer, then drains it one element per transfer.
module result_collector_128x1 #(
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    result_collector_128x1_if.slave bus
);
    localparam int NUM_LANES = 8;
    localparam int DEPTH     = 128;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] DRAIN   = 1'b1;

    logic [0:0] state_q, state_d;
    logic [6:0] wr_base_q, wr_base_d;
    logic [6:0] rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0] buf_q [DEPTH];

    logic [NUM_LANES-1:0][DATA_W-1:0] lane;
    logic accept, xfer;

    assign lane   = bus.in_data;
    assign accept = (state_q == COLLECT) && bus.in_valid;
    assign xfer   = (state_q == DRAIN) && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        wr_base_d = wr_base_q;
        rd_idx_d  = rd_idx_q;
        if (accept) begin
            wr_base_d = wr_base_q + 7'd8;
            if (wr_base_q == 7'd120) begin
                state_d  = DRAIN;
                rd_idx_d = 7'd0;
            end
        end
        if (xfer) begin
            rd_idx_d = rd_idx_q + 7'd1;
            if (rd_idx_q == 7'd127) state_d = COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= COLLECT;
            wr_base_q <= 7'd0;
            rd_idx_q  <= 7'd0;
        end else begin
            state_q   <= state_d;
            wr_base_q <= wr_base_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    // Buffer has no reset; stale contents are always overwritten before a drain exposes them.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                buf_q[{wr_base_q[6:3], 3'(k)}] <= lane[k];
            end
        end
    end

    assign bus.in_ready   = (state_q == COLLECT);
    assign bus.out_valid  = (state_q == DRAIN);
    assign bus.out_data   = buf_q[rd_idx_q];
    assign bus.out_idx    = rd_idx_q;
    assign bus.beat_cnt   = wr_base_q[6:3];
    assign bus.frame_done = xfer && (rd_idx_q == 7'd127);
endmodule
